// File: rtl/regfile_scoreboard.sv
// Parametrised register file with a pending-write scoreboard, RAW-hazard stall and branch-capable PC.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writeback data to reads and to the hazard check.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 2,
    parameter int PC_STEP    = 2,
    parameter int RESET_PC   = 0
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [ADDR_WIDTH-1:0]      RS,
    input  logic [ADDR_WIDTH-1:0]      RT,
    output logic [DATA_WIDTH-1:0]      ReadRS,
    output logic [DATA_WIDTH-1:0]      ReadRT,
    input  logic                       IssueValid,
    input  logic                       IssueRegWrite,
    input  logic [ADDR_WIDTH-1:0]      IssueRD,
    input  logic                       BranchEn,
    input  logic                       BranchNE,
    input  logic [DATA_WIDTH-1:0]      BranchOffset,
    input  logic [ADDR_WIDTH-1:0]      RD,
    input  logic [DATA_WIDTH-1:0]      WriteData,
    input  logic                       RegWrite,
    output logic                       Stall,
    output logic [2**ADDR_WIDTH-1:0]   Pending,
    output logic [DATA_WIDTH-1:0]      PC_out
);
    localparam int REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_reg [REGS];
    logic [REGS-1:0]       pending_reg;
    logic [REGS-1:0]       clear_vec;
    logic [REGS-1:0]       set_vec;
    logic [REGS-1:0]       hit_vec;
    logic [DATA_WIDTH-1:0] pc_reg;
    logic [DATA_WIDTH-1:0] pc_next;
    logic                  accept;
    logic                  taken;

    genvar gi;
    generate
        for (gi = 0; gi < REGS; gi++) begin : g_decode
            assign clear_vec[gi] = RegWrite && (RD == ADDR_WIDTH'(gi));
            assign set_vec[gi]   = accept && IssueRegWrite && (IssueRD == ADDR_WIDTH'(gi));
        end
    endgenerate

`ifdef REGFILE_BYPASS_EN
    // A register being written back this cycle is already resolved for readers.
    assign ReadRS  = (RegWrite && (RD == RS)) ? WriteData : regs_reg[RS];
    assign ReadRT  = (RegWrite && (RD == RT)) ? WriteData : regs_reg[RT];
    assign hit_vec = pending_reg & ~clear_vec;
`else
    assign ReadRS  = regs_reg[RS];
    assign ReadRT  = regs_reg[RT];
    assign hit_vec = pending_reg;
`endif

    assign Stall   = IssueValid && (hit_vec[RS] || hit_vec[RT]);
    assign accept  = IssueValid && !Stall;
    assign taken   = BranchEn && ((ReadRS == ReadRT) ^ BranchNE);
    assign pc_next = pc_reg + (taken ? BranchOffset : DATA_WIDTH'(PC_STEP));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (RegWrite) begin
            regs_reg[RD] <= WriteData;
        end
    end

    // An issue setting a bit wins over a writeback clearing the same bit.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= (pending_reg & ~clear_vec) | set_vec;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pc_reg <= DATA_WIDTH'(RESET_PC);
        end else if (accept) begin
            pc_reg <= pc_next;
        end
    end

    assign Pending = pending_reg;
    assign PC_out  = pc_reg;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed test-plan cases plus randomized traffic
// checked against an architectural model; follows REGFILE_BYPASS_EN when it is defined.
module tb_regfile_scoreboard;
    logic        Clock;
    logic        Reset;
    logic [1:0]  RS, RT, IssueRD, RD;
    logic [15:0] ReadRS, ReadRT, BranchOffset, WriteData, PC_out;
    logic        IssueValid, IssueRegWrite, BranchEn, BranchNE, RegWrite, Stall;
    logic [3:0]  Pending;

    int n_checks = 0;
    int n_errors = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // architectural model
    logic [15:0] m_regs [4];
    logic [3:0]  m_pend;
    logic [15:0] m_pc;
    logic        obs_stall;
    logic [15:0] obs_rs;

    regfile_scoreboard #(
        .DATA_WIDTH(16), .ADDR_WIDTH(2), .PC_STEP(2), .RESET_PC(0)
    ) dut (
        .Clock(Clock), .Reset(Reset), .RS(RS), .RT(RT), .ReadRS(ReadRS), .ReadRT(ReadRT),
        .IssueValid(IssueValid), .IssueRegWrite(IssueRegWrite), .IssueRD(IssueRD),
        .BranchEn(BranchEn), .BranchNE(BranchNE), .BranchOffset(BranchOffset),
        .RD(RD), .WriteData(WriteData), .RegWrite(RegWrite),
        .Stall(Stall), .Pending(Pending), .PC_out(PC_out)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic fwd(input logic [1:0] a);
        return BYPASS && RegWrite && (RD == a);
    endfunction

    function automatic logic [15:0] m_read(input logic [1:0] a);
        return fwd(a) ? WriteData : m_regs[a];
    endfunction

    function automatic logic m_stall();
        return IssueValid && ((m_pend[RS] && !fwd(RS)) || (m_pend[RT] && !fwd(RT)));
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 16'h0;
        m_pend = 4'h0;
        m_pc   = 16'h0;
    endtask

    task automatic drive(input logic iv, input logic irw, input logic [1:0] ird,
                         input logic [1:0] rs, input logic [1:0] rt, input logic be,
                         input logic bne, input logic [15:0] off, input logic [1:0] rd,
                         input logic [15:0] wd, input logic rw);
        IssueValid = iv; IssueRegWrite = irw; IssueRD = ird; RS = rs; RT = rt;
        BranchEn = be; BranchNE = bne; BranchOffset = off; RD = rd; WriteData = wd; RegWrite = rw;
    endtask

    // Called at a falling edge with inputs already driven; ends at the next falling edge.
    task automatic run_cycle();
        logic [15:0] a, b;
        logic        st;
        #1;
        a = m_read(RS);
        b = m_read(RT);
        st = m_stall();
        obs_stall = Stall;
        obs_rs    = ReadRS;
        check_value("read_rs", ReadRS, a);
        check_value("read_rt", ReadRT, b);
        check_value("stall", Stall, st);
        @(posedge Clock);
        if (RegWrite) begin
            m_regs[RD] = WriteData;
            m_pend[RD] = 1'b0;
        end
        if (IssueValid && !st) begin
            if (IssueRegWrite) m_pend[IssueRD] = 1'b1;
            if (BranchEn && ((a == b) != BranchNE)) m_pc = m_pc + BranchOffset;
            else m_pc = m_pc + 16'd2;
        end
        @(negedge Clock);
        check_value("pc", PC_out, m_pc);
        check_value("pending", Pending, m_pend);
        $display("txn iv=%0d rs=%0d rt=%0d br=%0d wb=%0d rd=%0d stall=%0d pc=%h pend=%b",
                 IssueValid, RS, RT, BranchEn, RegWrite, RD, obs_stall, PC_out, Pending);
    endtask

    initial begin
        logic [15:0] off;
        Reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 16'h0, 0);
        m_reset();
        #2;
        check_value("rst_pc", PC_out, 16'h0000);
        check_value("rst_pending", Pending, 4'h0);
        check_value("rst_stall", Stall, 1'b0);
        @(negedge Clock);
        Reset = 1'b0;

        for (int r = 0; r < 4; r++) begin
            drive(0, 0, 0, 2'(r), 2'(r), 0, 0, 16'h0, 0, 16'h0, 0);
            run_cycle();
            check_value("rst_reg_zero", obs_rs, 16'h0000);
        end

        // branch compare
        drive(0, 0, 0, 0, 0, 0, 0, 16'h0, 1, 16'h1234, 1); run_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 16'h0, 2, 16'h1234, 1); run_cycle();
        drive(1, 0, 0, 1, 2, 1, 0, 16'h0010, 0, 16'h0, 0); run_cycle();
        check_value("pc_to_10", PC_out, 16'h0010);
        drive(1, 0, 0, 1, 2, 1, 0, 16'hFFFC, 0, 16'h0, 0); run_cycle();
        check_value("beq_taken", PC_out, 16'h000C);
        drive(1, 0, 0, 1, 2, 1, 0, 16'h0004, 0, 16'h0, 0); run_cycle();
        drive(1, 0, 0, 1, 2, 1, 1, 16'hFFFC, 0, 16'h0, 0); run_cycle();
        check_value("bne_not_taken", PC_out, 16'h0012);

        // RAW hazard on R3
        drive(1, 1, 3, 0, 0, 0, 0, 16'h0, 0, 16'h0, 0); run_cycle();
        check_value("pending_r3", Pending, 4'b1000);
        drive(1, 0, 0, 3, 0, 0, 0, 16'h0, 0, 16'h0, 0); run_cycle();
        check_value("hazard_stall", obs_stall, 1'b1);
        check_value("hazard_pc_hold", PC_out, 16'h0014);
        drive(1, 0, 0, 3, 0, 0, 0, 16'h0, 3, 16'hBEEF, 1); run_cycle();
        check_value("wb_cycle_stall", obs_stall, BYPASS ? 1'b0 : 1'b1);
        check_value("wb_cycle_read", obs_rs, BYPASS ? 16'hBEEF : 16'h0000);
        drive(1, 0, 0, 3, 0, 0, 0, 16'h0, 0, 16'h0, 0); run_cycle();
        check_value("after_wb_stall", obs_stall, 1'b0);
        check_value("after_wb_read", obs_rs, 16'hBEEF);

        // set wins over same-cycle clear
        drive(1, 1, 2, 0, 0, 0, 0, 16'h0, 2, 16'h7777, 1); run_cycle();
        check_value("set_wins", Pending[2], 1'b1);

        // PC wrap
        off = 16'hFFFE - m_pc;
        drive(1, 0, 0, 0, 0, 1, 0, off, 0, 16'h0, 0); run_cycle();
        check_value("pc_fffe", PC_out, 16'hFFFE);
        drive(1, 0, 0, 0, 0, 0, 0, 16'h0, 0, 16'h0, 0); run_cycle();
        check_value("pc_wrap", PC_out, 16'h0000);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            drive(($urandom % 4) != 0, 1'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                  ($urandom % 3) == 0, 1'($urandom), 16'($urandom), 2'($urandom),
                  16'($urandom), 1'($urandom));
            run_cycle();
        end

        // drain scoreboard, then build Pending=0110 and reset mid-stall
        for (int r = 0; r < 4; r++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 16'h0, 2'(r), (r == 1) ? 16'h5555 : 16'($urandom), 1);
            run_cycle();
        end
        drive(1, 1, 1, 0, 0, 0, 0, 16'h0, 0, 16'h0, 0); run_cycle();
        drive(1, 1, 2, 0, 0, 0, 0, 16'h0, 0, 16'h0, 0); run_cycle();
        check_value("pending_0110", Pending, 4'b0110);
        drive(1, 0, 0, 1, 2, 0, 0, 16'h0, 0, 16'h0, 0);
        #1;
        check_value("pre_reset_stall", Stall, 1'b1);
        Reset = 1'b1;
        #1;
        m_reset();
        check_value("midrst_pending", Pending, 4'h0);
        check_value("midrst_stall", Stall, 1'b0);
        check_value("midrst_pc", PC_out, 16'h0000);
        check_value("midrst_read_r1", ReadRS, 16'h0000);
        check_value("midrst_read_r2", ReadRT, 16'h0000);
        @(negedge Clock);
        Reset = 1'b0;
        drive(1, 0, 0, 1, 2, 0, 0, 16'h0, 0, 16'h0, 0); run_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
